// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register-file writeback scheduler
package regfile_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEF_BIT_WIDTH       = 32;
  localparam int DEF_REG_INDEX_WIDTH = 4;

  localparam int SB_CNT_W = 2;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback sources, issue port, register-file write port and scoreboard status
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int BIT_WIDTH       = DEF_BIT_WIDTH,
  parameter int REG_INDEX_WIDTH = DEF_REG_INDEX_WIDTH
);
  localparam int NUM_REGS = 2 ** REG_INDEX_WIDTH;

  logic                       a_valid;
  logic                       a_ready;
  logic [REG_INDEX_WIDTH-1:0] a_dr;
  logic [BIT_WIDTH-1:0]       a_data;
  logic                       b_valid;
  logic                       b_ready;
  logic [REG_INDEX_WIDTH-1:0] b_dr;
  logic [BIT_WIDTH-1:0]       b_data;
  logic                       issue_valid;
  logic [REG_INDEX_WIDTH-1:0] issue_dr;
  logic                       rf_en_write;
  logic [REG_INDEX_WIDTH-1:0] rf_dr_ind;
  logic [BIT_WIDTH-1:0]       rf_data_in;
  logic                       rf_grant_b;
  logic [NUM_REGS-1:0]        busy;
  logic                       sb_err;

  modport master (
    output a_valid, a_dr, a_data, b_valid, b_dr, b_data, issue_valid, issue_dr,
    input  a_ready, b_ready, rf_en_write, rf_dr_ind, rf_data_in, rf_grant_b, busy, sb_err
  );

  modport slave (
    input  a_valid, a_dr, a_data, b_valid, b_dr, b_data, issue_valid, issue_dr,
    output a_ready, b_ready, rf_en_write, rf_dr_ind, rf_data_in, rf_grant_b, busy, sb_err
  );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - two-entry synchronous FIFO holding {dr, data} writebacks for one source
module wb_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'(DEPTH));
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin scheduler for the shared register-file write port with pending-write scoreboard
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int BIT_WIDTH       = DEF_BIT_WIDTH,
  parameter int REG_INDEX_WIDTH = DEF_REG_INDEX_WIDTH,
  parameter int FIFO_DEPTH      = 2
) (
  input logic                  clk,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int NUM_REGS = 2 ** REG_INDEX_WIDTH;
  localparam int ENTRY_W  = REG_INDEX_WIDTH + BIT_WIDTH;

  logic               a_full, a_empty, b_full, b_empty;
  logic [ENTRY_W-1:0] a_head, b_head;
  logic               a_ready, b_ready;
  logic               a_push, b_push, a_pop, b_pop;
  logic               last_grant;
  logic               grant_b;
  logic               en_write;
  logic [ENTRY_W-1:0] sel_head;
  logic [REG_INDEX_WIDTH-1:0] dr_ind;
  logic [BIT_WIDTH-1:0]       data_in;

  sb_cnt_t             cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] busy;
  logic                err_now;
  logic                sb_err;

  assign a_ready = !a_full && !reset;
  assign b_ready = !b_full && !reset;
  assign a_push  = bus.a_valid && a_ready;
  assign b_push  = bus.b_valid && b_ready;

  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk   (clk),
    .reset (reset),
    .push  (a_push),
    .pop   (a_pop),
    .din   ({bus.a_dr, bus.a_data}),
    .full  (a_full),
    .empty (a_empty),
    .head  (a_head)
  );

  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk   (clk),
    .reset (reset),
    .push  (b_push),
    .pop   (b_pop),
    .din   ({bus.b_dr, bus.b_data}),
    .full  (b_full),
    .empty (b_empty),
    .head  (b_head)
  );

  // On a tie the source opposite to the previous grant wins.
  always_comb begin
    grant_b  = !b_empty && (a_empty || (last_grant == SRC_A));
    en_write = (!a_empty || !b_empty) && !reset;
    sel_head = grant_b ? b_head : a_head;
    dr_ind   = '0;
    data_in  = '0;
    if (en_write) begin
      {dr_ind, data_in} = sel_head;
    end
  end

  assign a_pop = en_write && !grant_b;
  assign b_pop = en_write && grant_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SRC_B;
    end else if (en_write) begin
      last_grant <= grant_b;
    end
  end

  always_comb begin
    inc_vec = NUM_REGS'(bus.issue_valid) << bus.issue_dr;
    dec_vec = NUM_REGS'(en_write) << dr_ind;
    err_now = 1'b0;
    busy    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy[i] = (cnt[i] != '0);
      if (inc_vec[i] && !dec_vec[i] && (cnt[i] == SB_CNT_MAX)) err_now = 1'b1;
      if (dec_vec[i] && !inc_vec[i] && (cnt[i] == '0))         err_now = 1'b1;
    end
  end

  // Counters saturate at both ends; the error flag records the violation.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sb_err <= sb_err || err_now;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i] && (cnt[i] != SB_CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  assign bus.a_ready     = a_ready;
  assign bus.b_ready     = b_ready;
  assign bus.rf_en_write = en_write;
  assign bus.rf_dr_ind   = dr_ind;
  assign bus.rf_data_in  = data_in;
  assign bus.rf_grant_b  = en_write && grant_b;
  assign bus.busy        = busy;
  assign bus.sb_err      = sb_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] rf_model [16];

  regfile_wb_arbiter_if #(.BIT_WIDTH(32), .REG_INDEX_WIDTH(4)) bus ();

  regfile_wb_arbiter #(.BIT_WIDTH(32), .REG_INDEX_WIDTH(4), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rf_en_write) rf_model[bus.rf_dr_ind] <= bus.rf_data_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_dr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_dr = '0; bus.b_data = '0;
    bus.issue_valid = 1'b0; bus.issue_dr = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next();
    reset = 1'b0;
  endtask

  task automatic push_a(input logic [3:0] dr, input logic [31:0] d);
    bus.a_valid = 1'b1; bus.a_dr = dr; bus.a_data = d;
  endtask

  task automatic push_b(input logic [3:0] dr, input logic [31:0] d);
    bus.b_valid = 1'b1; bus.b_dr = dr; bus.b_data = d;
  endtask

  task automatic issue(input logic [3:0] dr);
    bus.issue_valid = 1'b1; bus.issue_dr = dr;
  endtask

  task automatic check_commit(input string tag, input logic [3:0] dr, input logic [31:0] d, input logic gb);
    check_eq({tag, "_en"}, 32'(bus.rf_en_write), 32'd1);
    check_eq({tag, "_dr"}, 32'(bus.rf_dr_ind), 32'(dr));
    check_eq({tag, "_data"}, bus.rf_data_in, d);
    check_eq({tag, "_gb"}, 32'(bus.rf_grant_b), 32'(gb));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    idle();
    reset = 1'b1;
    #1;
    check_eq("rst_a_ready", 32'(bus.a_ready), 32'd0);
    check_eq("rst_b_ready", 32'(bus.b_ready), 32'd0);
    check_eq("rst_en", 32'(bus.rf_en_write), 32'd0);
    next();
    reset = 1'b0;
    #1;
    check_eq("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
    check_eq("post_rst_b_ready", 32'(bus.b_ready), 32'd1);
    check_eq("post_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("post_rst_err", 32'(bus.sb_err), 32'd0);
    check_eq("post_rst_en", 32'(bus.rf_en_write), 32'd0);
    check_eq("post_rst_dr", 32'(bus.rf_dr_ind), 32'd0);
    check_eq("post_rst_data", bus.rf_data_in, 32'd0);
    check_eq("post_rst_gb", 32'(bus.rf_grant_b), 32'd0);

    // single A writeback, one cycle latency, no bypass
    push_a(4'd1, 32'd9);
    issue(4'd1);
    #1;
    check_eq("t1_a_ready", 32'(bus.a_ready), 32'd1);
    check_eq("t1_no_bypass", 32'(bus.rf_en_write), 32'd0);
    next();
    idle();
    #1;
    check_commit("t1", 4'd1, 32'd9, 1'b0);
    check_eq("t1_busy", 32'(bus.busy), 32'h0002);
    next();
    #1;
    check_eq("t1_rf1", rf_model[1], 32'd9);
    check_eq("t1_idle", 32'(bus.rf_en_write), 32'd0);
    check_eq("t1_busy_clr", 32'(bus.busy), 32'd0);
    check_eq("t1_err", 32'(bus.sb_err), 32'd0);

    // round-robin between A and B
    do_reset();
    issue(4'd2); next();
    issue(4'd2); next();
    issue(4'd3); next();
    issue(4'd3); next();
    idle();
    #1;
    check_eq("t2_busy", 32'(bus.busy), 32'h000C);
    push_a(4'd2, 32'd10); push_b(4'd3, 32'd20);
    next();
    push_a(4'd2, 32'd11); push_b(4'd3, 32'd21);
    #1;
    check_eq("t2_a_ready", 32'(bus.a_ready), 32'd1);
    check_eq("t2_b_ready", 32'(bus.b_ready), 32'd1);
    check_commit("t2_c0", 4'd2, 32'd10, 1'b0);
    next();
    idle();
    #1;
    check_commit("t2_c1", 4'd3, 32'd20, 1'b1);
    next(); #1;
    check_commit("t2_c2", 4'd2, 32'd11, 1'b0);
    next(); #1;
    check_commit("t2_c3", 4'd3, 32'd21, 1'b1);
    next(); #1;
    check_eq("t2_idle", 32'(bus.rf_en_write), 32'd0);
    check_eq("t2_busy_clr", 32'(bus.busy), 32'd0);
    check_eq("t2_err", 32'(bus.sb_err), 32'd0);

    // A FIFO fills while B takes alternate slots
    do_reset();
    for (int r = 10; r < 16; r++) begin
      issue(4'(r));
      next();
    end
    idle();
    push_a(4'd10, 32'h100); push_b(4'd14, 32'h200);
    next();
    push_a(4'd11, 32'h101); push_b(4'd15, 32'h201);
    #1;
    check_commit("t3_c0", 4'd10, 32'h100, 1'b0);
    next();
    bus.b_valid = 1'b0;
    push_a(4'd12, 32'h102);
    #1;
    check_eq("t3_c1_a_ready", 32'(bus.a_ready), 32'd1);
    check_commit("t3_c1", 4'd14, 32'h200, 1'b1);
    next();
    push_a(4'd13, 32'h103);
    #1;
    check_eq("t3_full_a_ready", 32'(bus.a_ready), 32'd0);
    check_commit("t3_c2", 4'd11, 32'h101, 1'b0);
    next(); #1;
    check_eq("t3_c3_a_ready", 32'(bus.a_ready), 32'd1);
    check_commit("t3_c3", 4'd15, 32'h201, 1'b1);
    next();
    bus.a_valid = 1'b0;
    #1;
    check_eq("t3_full2_a_ready", 32'(bus.a_ready), 32'd0);
    check_commit("t3_c4", 4'd12, 32'h102, 1'b0);
    next(); #1;
    check_commit("t3_c5", 4'd13, 32'h103, 1'b0);
    next(); #1;
    check_eq("t3_idle", 32'(bus.rf_en_write), 32'd0);
    check_eq("t3_rf13", rf_model[13], 32'h103);
    check_eq("t3_busy_clr", 32'(bus.busy), 32'd0);
    check_eq("t3_err", 32'(bus.sb_err), 32'd0);

    // commit and issue on the same register in the same cycle
    do_reset();
    issue(4'd5);
    next();
    idle();
    push_a(4'd5, 32'h55);
    #1;
    check_eq("t4_busy_set", 32'(bus.busy), 32'h0020);
    next();
    idle();
    issue(4'd5);
    #1;
    check_commit("t4_c0", 4'd5, 32'h55, 1'b0);
    next();
    idle();
    push_a(4'd5, 32'h56);
    #1;
    check_eq("t4_busy_hold", 32'(bus.busy), 32'h0020);
    next();
    idle();
    #1;
    check_commit("t4_c1", 4'd5, 32'h56, 1'b0);
    next(); #1;
    check_eq("t4_busy_clr", 32'(bus.busy), 32'd0);
    check_eq("t4_err", 32'(bus.sb_err), 32'd0);

    // scoreboard overflow then underflow
    do_reset();
    for (int k = 0; k < 3; k++) begin
      issue(4'd7);
      next();
    end
    #1;
    check_eq("t5_no_err_at3", 32'(bus.sb_err), 32'd0);
    issue(4'd7);
    next();
    idle();
    #1;
    check_eq("t5_overflow_err", 32'(bus.sb_err), 32'd1);
    check_eq("t5_busy", 32'(bus.busy), 32'h0080);
    next(); next(); #1;
    check_eq("t5_err_sticky", 32'(bus.sb_err), 32'd1);
    do_reset();
    #1;
    check_eq("t5_err_clr", 32'(bus.sb_err), 32'd0);
    push_a(4'd4, 32'h44);
    next();
    idle();
    #1;
    check_eq("t5_pre_underflow", 32'(bus.sb_err), 32'd0);
    next(); #1;
    check_eq("t5_underflow_err", 32'(bus.sb_err), 32'd1);
    check_eq("t5_busy_zero", 32'(bus.busy), 32'd0);

    // reset while both FIFOs hold entries
    do_reset();
    issue(4'd1); push_a(4'd1, 32'hA1); push_b(4'd2, 32'hB2);
    next();
    idle();
    issue(4'd2);
    push_a(4'd1, 32'hA1);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_en", 32'(bus.rf_en_write), 32'd0);
    check_eq("t6_rst_a_ready", 32'(bus.a_ready), 32'd0);
    check_eq("t6_rst_b_ready", 32'(bus.b_ready), 32'd0);
    next();
    reset = 1'b0;
    idle();
    #1;
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_empty", 32'(bus.rf_en_write), 32'd0);
    check_eq("t6_a_ready", 32'(bus.a_ready), 32'd1);
    issue(4'd3); push_a(4'd3, 32'h33); push_b(4'd4, 32'h44);
    next();
    idle();
    issue(4'd4);
    #1;
    check_commit("t6_c0", 4'd3, 32'h33, 1'b0);
    next();
    idle();
    #1;
    check_commit("t6_c1", 4'd4, 32'h44, 1'b1);
    next(); #1;
    check_eq("t6_idle", 32'(bus.rf_en_write), 32'd0);
    check_eq("t6_busy_clr", 32'(bus.busy), 32'd0);
    check_eq("t6_err", 32'(bus.sb_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port scheduler for the 16x32 register file.
- Shares the single register-file write port between two writeback sources: A (ALU path) and B (load path).
- Each source has a small FIFO. When both have data, a round-robin arbiter picks one.
- A per-register pending-write scoreboard tells the decode stage which registers still have writes in flight.
- Drives the register file's en_write / dr_ind / data_in directly.

Parameters:
- BIT_WIDTH, 32, data width of a writeback.
- REG_INDEX_WIDTH, 4, register index width; NUM_REGS = 2**REG_INDEX_WIDTH (derived, not overridable).
- FIFO_DEPTH, 2, entries per source FIFO; must be 2 in this revision.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- a_valid  input  1  source A has a writeback.
- a_ready  output  1  source A may be accepted.
- a_dr  input  REG_INDEX_WIDTH  destination register for A.
- a_data  input  BIT_WIDTH  writeback data for A.
- b_valid, b_ready, b_dr, b_data  same as A, for source B.
- issue_valid  input  1  an instruction writing issue_dr was issued.
- issue_dr  input  REG_INDEX_WIDTH  destination of the issued instruction.
- rf_en_write  output  1  to register file en_write.
- rf_dr_ind  output  REG_INDEX_WIDTH  to register file dr_ind.
- rf_data_in  output  BIT_WIDTH  to register file data_in.
- rf_grant_b  output  1  1 = current write comes from B.
- busy  output  NUM_REGS  bit i = register i has a write pending.
- sb_err  output  1  sticky scoreboard protocol error.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high; all state clears on a rising edge where reset=1.
- Reset values:
  - FIFOs empty; last_grant = B, so A wins the first tie.
  - All scoreboard counters 0; sb_err = 0.
  - busy = 0, rf_en_write = 0, rf_dr_ind = 0, rf_data_in = 0, rf_grant_b = 0.
- Reset mid-operation: in any cycle where reset=1, a_ready, b_ready and rf_en_write are forced to 0. No write commits and no source is accepted in that cycle. Queued entries are discarded.
- Accept handshake:
  - X_ready = (FIFO_X count < FIFO_DEPTH) and !reset. It never depends on X_valid.
  - A transfer occurs when X_valid && X_ready at the rising edge; {dr, data} is enqueued.
  - Full FIFO: ready=0 even if a dequeue occurs in the same cycle (no pass-through).
- Latency: entry accepted at edge N, so rf_en_write can be high in the cycle after N and the register file updates at edge N+1. There is no same-cycle bypass from input to rf_*.
- rf_* outputs are combinational from registered state only (FIFO heads, last_grant). There is no combinational path from a_*/b_* inputs.
- Arbitration, evaluated each cycle:
  - Only A non-empty: grant A.
  - Only B non-empty: grant B.
  - Both non-empty: grant the source opposite to last_grant.
  - Neither non-empty: rf_en_write=0 and rf_dr_ind/rf_data_in = 0.
  - On every grant, the granted head is dequeued at the next edge and last_grant updates.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, order preserved.
- Scoreboard: one 2-bit counter per register.
  - Increment on issue_valid for issue_dr.
  - Decrement on rf_en_write for rf_dr_ind.
  - Increment and decrement of the same register in the same cycle: no change.
  - Increment at count 3: hold at 3 and set sb_err.
  - Decrement at count 0: hold at 0 and set sb_err.
  - sb_err stays set until reset.
  - busy[i] = (count_i != 0), taken from registered counts. A register issued at edge N shows busy in the cycle after N.
- Ordering: ordering within one source is FIFO order. Across sources, ordering for the same register is not guaranteed; the issuing stage must not have two in-flight writes to the same register on different sources. The scoreboard remains correct regardless.

Decomposition:
- Shared package/header regfile_pkg holds:
  - SRC_A = 1'b0, SRC_B = 1'b1;
  - default BIT_WIDTH and REG_INDEX_WIDTH;
  - the scoreboard counter width SB_CNT_W = 2.
- One sub-module, wb_fifo: a 2-entry synchronous FIFO (push/pop/full/empty/head), instantiated once per source.
- Arbiter and scoreboard stay in the top module.

Test Plan:
- Reset, then A sends {dr=1, data=9} → a_ready=1; next cycle rf_en_write=1, rf_dr_ind=1, rf_data_in=9, rf_grant_b=0; register 1 reads 9 after that edge.
- A and B both hold valid for 4 cycles: A sends dr=2, data 10,11; B sends dr=3, data 20,21 → commit order A10, B20, A11, B21.
- Three back-to-back A pushes with no competition and the FIFO held full by B-priority stalls → a_ready=0 when count=2; no entry lost; data emerges in push order.
- issue_valid on dr=5 → busy[5]=1 the next cycle. Commit to dr=5 together with a new issue on dr=5 in the same cycle → busy[5] stays 1, counter unchanged. Final commit → busy[5]=0.
- Four issues to dr=7 with no commit → sb_err=1 and stays 1. A commit to dr=4 with count 0 after reset → sb_err=1.
- Reset asserted while both FIFOs are non-empty → in that cycle rf_en_write=0 and a_ready=b_ready=0; the following cycle busy=0 and FIFOs are empty; a tie then grants A first.
